// File: rtl/dict_ram_arbiter_pkg.sv
// Shared definitions for the LZW dictionary RAM arbiter: default widths,
// FSM state encoding and arbiter requester indices.
package dict_ram_arbiter_pkg;

  localparam int unsigned DICT_ADDR_W = 12;
  localparam int unsigned DICT_DATA_W = 16;

  // Requester slots in the 2-way arbiter vectors.
  localparam int unsigned RdIdx = 0;
  localparam int unsigned WrIdx = 1;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StIdle = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dict_ram_arbiter_if.sv
// Search-read and insert-write handshake bundle between the LZW datapath
// (master) and the dictionary RAM arbiter (slave).
interface dict_ram_arbiter_if
  import dict_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DICT_ADDR_W,
  parameter int unsigned DATA_W = DICT_DATA_W
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_gnt, rd_valid, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_valid, rd_data, wr_gnt
  );

endinterface

// File: rtl/dict_ram_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with per-requester masks. Only true conflicts
// (both requesting, neither masked) consult and update the last-winner bit.
module rr_arbiter2
  import dict_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  // Index of the last conflict winner; reset to read so write wins first.
  logic       last_q, last_d;
  logic [1:0] live;

  // Combinational grant: single live request wins, conflicts alternate.
  always_comb begin
    live   = req_i & ~mask_i & {2{en_i}};
    gnt_o  = live;
    last_d = last_q;
    if (&live) begin
      gnt_o          = '0;
      gnt_o[WrIdx]   = ~last_q;
      gnt_o[RdIdx]   = last_q;
      last_d         = ~last_q;
    end
  end

  // Last-winner register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dict_ram_arbiter.sv
// Single-port LZW dictionary RAM arbiter: zero-fill sweep after reset or on
// init_req, then round-robin sharing between search reads and insert writes.
// All RAM-side outputs are registered; read data returns two cycles after
// the request is sampled.
// Optional feature macro: ARB_STATS_EN adds saturating grant/conflict counters.
module dict_ram_arbiter
  import dict_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DICT_ADDR_W,
  parameter int unsigned DATA_W = DICT_DATA_W
`ifdef ARB_STATS_EN
  ,
  parameter int unsigned STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req_i,
  output logic              busy_o,
  dict_ram_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_re_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stat_rd_cnt_o,
  output logic [STAT_W-1:0] stat_wr_cnt_o,
  output logic [STAT_W-1:0] stat_conf_cnt_o
`endif
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              busy_q, busy_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_valid_q;
  logic              ram_re_q, ram_re_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]        arb_gnt;
  logic              arb_en;

  // No grants while sweeping or in the cycle that requests a new sweep.
  assign arb_en = (state_q == StIdle) && !init_req_i;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (arb_en),
    .req_i  ({bus.wr_req, bus.rd_req}),
    .mask_i ({wr_gnt_q, rd_gnt_q}),
    .gnt_o  (arb_gnt)
  );

  // Next-state: sweep sequencing, mode changes and RAM command selection.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    ram_re_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_gnt_d    = arb_gnt[RdIdx];
    wr_gnt_d    = arb_gnt[WrIdx];
    unique case (state_q)
      StInit: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = sweep_q;
        ram_wdata_d = '0;
        if (init_req_i) begin
          sweep_d = '0;
        end else if (sweep_q == '1) begin
          state_d = StIdle;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + ADDR_W'(1);
        end
      end
      StIdle: begin
        if (init_req_i) begin
          state_d = StInit;
          sweep_d = '0;
        end else if (arb_gnt[WrIdx]) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = bus.wr_addr;
          ram_wdata_d = bus.wr_data;
        end else if (arb_gnt[RdIdx]) begin
          ram_re_d   = 1'b1;
          ram_addr_d = bus.rd_addr;
        end
      end
      default: state_d = StInit;
    endcase
    busy_d = (state_d == StInit);
  end

  // FSM and registered outputs; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      busy_q      <= 1'b1;
      rd_gnt_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      busy_q      <= busy_d;
      rd_gnt_q    <= rd_gnt_d;
      wr_gnt_q    <= wr_gnt_d;
      rd_valid_q  <= rd_gnt_q;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign busy_o       = busy_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_re_o     = ram_re_q;
  assign ram_we_o     = ram_we_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign bus.rd_gnt   = rd_gnt_q;
  assign bus.wr_gnt   = wr_gnt_q;
  assign bus.rd_valid = rd_valid_q;
  // RAM read data is only forwarded in its valid cycle.
  assign bus.rd_data  = rd_valid_q ? ram_rdata_i : '0;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] rd_cnt_q, wr_cnt_q, conf_cnt_q;
  logic              conf_hit;

  assign conf_hit = arb_en & bus.rd_req & bus.wr_req & ~rd_gnt_q & ~wr_gnt_q;

  // Saturating counters; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clr_i) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (rd_gnt_d && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + STAT_W'(1);
      if (wr_gnt_d && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + STAT_W'(1);
      if (conf_hit && (conf_cnt_q != '1)) conf_cnt_q <= conf_cnt_q + STAT_W'(1);
    end
  end

  assign stat_rd_cnt_o   = rd_cnt_q;
  assign stat_wr_cnt_o   = wr_cnt_q;
  assign stat_conf_cnt_o = conf_cnt_q;
`endif

endmodule
